// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings of the core's 8-bit ALU and the
// multiply-sequencer state enumeration.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_ADD = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;
   localparam logic [2:0] ALU_SHR = 3'b110;
   localparam logic [2:0] ALU_EQ  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } mulseq_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Bundle of the operand/product handshakes and the shared-ALU port group of
// the multiply sequencer; slave is the sequencer side, master the core side.
interface mul_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic        signed_op;
   logic        alu_req;
   logic        alu_gnt;
   logic [7:0]  alu_op1;
   logic [7:0]  alu_op2;
   logic [2:0]  alu_aluop;
   logic [1:0]  alu_control_in;
   logic [7:0]  alu_result;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] product;
   logic        busy;

   modport slave (
      input  req_valid, op_a, op_b, signed_op, alu_gnt, alu_result, resp_ready,
      output req_ready, alu_req, alu_op1, alu_op2, alu_aluop, alu_control_in,
             resp_valid, product, busy
   );

   modport master (
      output req_valid, op_a, op_b, signed_op, alu_gnt, alu_result, resp_ready,
      input  req_ready, alu_req, alu_op1, alu_op2, alu_aluop, alu_control_in,
             resp_valid, product, busy
   );
endinterface

// File: rtl/mul_sequencer.sv
// 8x8->16 shift-add multiplier borrowing the shared 8-bit ALU one iteration per grant.
// Optional two's-complement mode is enabled by defining MULSEQ_SIGNED_EN.
module mul_sequencer
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   mul_sequencer_if.slave bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_ITER = ITER;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0] state;
   logic [2:0] cnt;
   logic       sgn;
   logic [7:0] acc_hi;
   logic [7:0] acc_lo;
   logic [7:0] mcand;
   logic       accept;
   logic       step;
   logic       sub_it;
   logic       ext;
   logic [7:0] sum;

   // Bit 8 of the 9-bit sum/difference, recovered from the 8-bit ALU result
   // (unsigned: carry-out; signed: result sign corrected for overflow).
   function automatic logic ext_bit(input logic sel, input logic is_sgn,
                                    input logic is_sub, input logic [7:0] a,
                                    input logic [7:0] m, input logic [7:0] r);
      logic ovf;
      ovf = 1'b0;
      if (!sel)
         return is_sgn & a[7];
      if (!is_sgn)
         return (r < a);
      if (is_sub)
         ovf = (a[7] != m[7]) && (r[7] != a[7]);
      else
         ovf = (a[7] == m[7]) && (r[7] != a[7]);
      return r[7] ^ ovf;
   endfunction

   assign accept = (state == S_IDLE) && bus.req_valid;
   assign step   = (state == S_ITER) && bus.alu_gnt;
   assign sub_it = sgn && (cnt == 3'd7);
   assign sum    = acc_lo[0] ? bus.alu_result : acc_hi;
   assign ext    = ext_bit(acc_lo[0], sgn, sub_it, acc_hi, mcand, bus.alu_result);

`ifdef MULSEQ_SIGNED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sgn <= 1'b0;
      else if (accept)
         sgn <= bus.signed_op;
   end
`else
   assign sgn = 1'b0;
`endif

   // Control: state and iteration count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= 3'd0;
      end else begin
         case (state)
            S_IDLE: if (bus.req_valid) begin
               state <= S_ITER;
               cnt   <= 3'd0;
            end
            S_ITER: if (bus.alu_gnt) begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7)
                  state <= S_DONE;
            end
            S_DONE: if (bus.resp_ready)
               state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath: operands load on accept, shift once per granted iteration
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand  <= bus.op_a;
         acc_lo <= bus.op_b;
         acc_hi <= 8'h00;
      end else if (step) begin
         {acc_hi, acc_lo} <= {ext, sum, acc_lo[7:1]};
      end
   end

   assign bus.req_ready      = (state == S_IDLE);
   assign bus.busy           = (state != S_IDLE);
   assign bus.alu_req        = (state == S_ITER);
   assign bus.alu_op1        = (state == S_ITER) ? acc_hi : 8'h00;
   assign bus.alu_op2        = (state == S_ITER) ? mcand : 8'h00;
   assign bus.alu_aluop      = (state != S_ITER) ? 3'b000 : (sub_it ? ALU_SUB : ALU_ADD);
   assign bus.alu_control_in = 2'b00;
   assign bus.resp_valid     = (state == S_DONE);
   assign bus.product        = (state == S_DONE) ? {acc_hi, acc_lo} : 16'h0000;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: directed and random operand pairs with
// random ALU stalls and back-pressure, checked against a plain-arithmetic model.
module tb_mul_sequencer;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   mul_sequencer_if bus ();

   mul_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External shared ALU, combinational
   assign bus.alu_result = (bus.alu_aluop == ALU_ADD) ? bus.alu_op1 + bus.alu_op2 :
                           (bus.alu_aluop == ALU_SUB) ? bus.alu_op1 - bus.alu_op2 : 8'h00;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic signed [15:0] sp;
      logic [15:0] up;
      up = {8'h00, a} * {8'h00, b};
      sp = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
`ifdef MULSEQ_SIGNED_EN
      if (s) return sp;
`endif
      return up;
   endfunction

   // Monitor: every accepted product is compared with the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.resp_valid && bus.resp_ready) begin
         if (exp_q.size() == 0)
            check("unexpected_resp", {16'h0, bus.product}, 32'hFFFF_FFFF);
         else
            check("product", {16'h0, bus.product}, {16'h0, exp_q.pop_front()});
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'd1);
      check({tag, "_alu_req"}, {31'h0, bus.alu_req}, 32'd0);
      check({tag, "_resp_valid"}, {31'h0, bus.resp_valid}, 32'd0);
      check({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
      check({tag, "_product"}, {16'h0, bus.product}, 32'd0);
      check({tag, "_alu_ops"}, {11'h0, bus.alu_control_in, bus.alu_aluop, bus.alu_op2, bus.alu_op1}, 32'd0);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input int nstall, input int hold);
      int lat, granted, stalls_left, w;
      logic stalled;
      logic [7:0] op1_pre;
      logic [15:0] exp;
      exp = model(a, b, s);
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      check("req_ready_wait", {31'h0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.op_a       = a;
      bus.op_b       = b;
      bus.signed_op  = s;
      bus.resp_ready = (hold == 0);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      lat = 1;
      granted = 0;
      stalls_left = nstall;
      while (!bus.resp_valid && lat < 40) begin
         // Garbage requests while busy must be ignored
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.op_a      = 8'($urandom);
         bus.op_b      = 8'($urandom);
         stalled = (stalls_left > 0) && (granted == 7 || $urandom_range(0, 1) == 1);
         bus.alu_gnt = !stalled;
         if (stalled) stalls_left--;
         @(negedge clk);
         op1_pre = bus.alu_op1;
         check("iter_alu_req", {30'h0, bus.alu_req, bus.busy}, 32'd3);
         @(posedge clk); #1;
         lat++;
         if (!stalled) granted++;
         else check("stall_frozen", {24'h0, bus.alu_op1}, {24'h0, op1_pre});
      end
      bus.alu_gnt = 1'b1;
      check("latency", lat, 32'(9 + nstall));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_product", {15'h0, bus.resp_valid, bus.product}, {15'h0, 1'b1, exp});
         @(posedge clk); #1;
      end
      bus.req_valid  = 1'b1;
      bus.op_a       = 8'hAA;
      bus.op_b       = 8'h55;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("no_accept_done_exit", {30'h0, bus.busy, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.op_a       = 8'h00;
      bus.op_b       = 8'h00;
      bus.signed_op  = 1'b0;
      bus.alu_gnt    = 1'b1;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'd13, 8'd11, 1'b0, 0, 0);
      run_op(8'd255, 8'd255, 1'b0, 0, 0);
      run_op(8'd0, 8'd200, 1'b0, 0, 0);
      run_op(8'd200, 8'd0, 1'b0, 0, 0);
      run_op(8'd7, 8'd9, 1'b0, 3, 0);
      run_op(8'hFD, 8'h05, 1'b1, 0, 0);
      run_op(8'h80, 8'h80, 1'b1, 0, 0);
      run_op(8'hFD, 8'h05, 1'b0, 0, 0);
      run_op(8'h7F, 8'h81, 1'b1, 2, 5);

      // Reset in the middle of an operation: no response, outputs at reset values
      bus.req_valid = 1'b1;
      bus.op_a      = 8'd100;
      bus.op_b      = 8'd77;
      bus.alu_gnt   = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(8'd2, 8'd3, 1'b0, 0, 0);

      for (int i = 0; i < 40; i++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 2));

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
